// File: rtl/input_conditioner_pkg.sv
// Shared defaults and debouncer decision encoding for the input conditioner.
package input_conditioner_pkg;

    localparam int DEFAULT_COUNTER_WIDTH = 3;
    localparam int DEFAULT_WAIT_TIME     = 3;

    typedef enum logic [1:0] {
        DB_IDLE   = 2'd0,
        DB_COUNT  = 2'd1,
        DB_ACCEPT = 2'd2
    } db_action_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, asynchronously reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic sync0_reg;
    logic sync1_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync0_reg <= 1'b0;
            sync1_reg <= 1'b0;
        end else begin
            sync0_reg <= d;
            sync1_reg <= sync0_reg;
        end
    end

    assign q = sync1_reg;

endmodule

// File: rtl/input_conditioner.sv
// Synchronizes and debounces one raw input, emitting registered one-cycle edge pulses.
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int COUNTER_WIDTH = DEFAULT_COUNTER_WIDTH,
    parameter int WAIT_TIME     = DEFAULT_WAIT_TIME
) (
    input  logic clk,
    input  logic reset,
    input  logic noisysignal,
    output logic conditioned,
    output logic positiveedge,
    output logic negativeedge
);

    localparam logic [COUNTER_WIDTH-1:0] WAIT_LIMIT = COUNTER_WIDTH'(WAIT_TIME);

    logic                     sync1;
    logic [COUNTER_WIDTH-1:0] count_reg, count_next;
    logic                     cond_reg, cond_next;
    logic                     pos_reg, pos_next;
    logic                     neg_reg, neg_next;
    db_action_t               action;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (noisysignal),
        .q     (sync1)
    );

    // Any agreeing sample drops back to IDLE, so a bounce restarts qualification.
    always_comb begin
        action = DB_IDLE;
        if (sync1 != cond_reg) begin
            if (count_reg < WAIT_LIMIT) begin
                action = DB_COUNT;
            end else begin
                action = DB_ACCEPT;
            end
        end
    end

    always_comb begin
        count_next = '0;
        cond_next  = cond_reg;
        pos_next   = 1'b0;
        neg_next   = 1'b0;
        case (action)
            DB_COUNT: begin
                count_next = count_reg + COUNTER_WIDTH'(1);
            end
            DB_ACCEPT: begin
                cond_next = sync1;
                pos_next  = sync1;
                neg_next  = ~sync1;
            end
            default: begin
                count_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
            cond_reg  <= 1'b0;
            pos_reg   <= 1'b0;
            neg_reg   <= 1'b0;
        end else begin
            count_reg <= count_next;
            cond_reg  <= cond_next;
            pos_reg   <= pos_next;
            neg_reg   <= neg_next;
        end
    end

    assign conditioned  = cond_reg;
    assign positiveedge = pos_reg;
    assign negativeedge = neg_reg;

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench: expected edge events are queued with their cycle and matched as pulses appear.
`timescale 1ns/100ps
module tb_input_conditioner;

    logic clk = 1'b0;
    logic reset;
    logic noisysignal;
    logic conditioned;
    logic positiveedge;
    logic negativeedge;

    localparam logic [2:0] EV_RISE = 3'b101;
    localparam logic [2:0] EV_FALL = 3'b010;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [31:0] exp_q[$];

    input_conditioner dut (
        .clk          (clk),
        .reset        (reset),
        .noisysignal  (noisysignal),
        .conditioned  (conditioned),
        .positiveedge (positiveedge),
        .negativeedge (negativeedge)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Event word: cycle number in the upper bits, {conditioned, negativeedge, positiveedge} below.
    task automatic push_event(input int at, input logic [2:0] kind);
        exp_q.push_back((32'(at) << 3) | {29'd0, kind});
    endtask

    always @(negedge clk) begin
        logic [31:0] ev;
        if (!reset && (positiveedge || negativeedge)) begin
            ev = (32'(cyc) << 3) | {29'd0, conditioned, negativeedge, positiveedge};
            $display("edge cyc=%0d pos=%0b neg=%0b cond=%0b", cyc, positiveedge, negativeedge, conditioned);
            if (exp_q.size() == 0) begin
                check("unexpected_edge", ev, 32'd0);
            end else begin
                check("edge_event", ev, exp_q.pop_front());
            end
        end
    end

    initial begin
        reset = 1'b1;
        noisysignal = 1'b1;

        // 1: outputs held low in reset, then a qualified rise from a high input
        wait_neg(3);
        check("rst_cond", {31'd0, conditioned}, 32'd0);
        check("rst_pos", {31'd0, positiveedge}, 32'd0);
        check("rst_neg", {31'd0, negativeedge}, 32'd0);
        reset = 1'b0;
        push_event(cyc + 6, EV_RISE);
        wait_neg(12);
        check("post_rst_level", {31'd0, conditioned}, 32'd1);

        // 2: clean steps held 200 ns
        noisysignal = 1'b0;
        push_event(cyc + 6, EV_FALL);
        wait_neg(10);
        check("step_fall_level", {31'd0, conditioned}, 32'd0);
        noisysignal = 1'b1;
        push_event(cyc + 6, EV_RISE);
        wait_neg(10);
        check("step_rise_level", {31'd0, conditioned}, 32'd1);
        noisysignal = 1'b0;
        push_event(cyc + 6, EV_FALL);
        wait_neg(10);
        check("step_fall2_level", {31'd0, conditioned}, 32'd0);

        // 3: short pulses spanning three sampling edges are dropped
        noisysignal = 1'b1;
        #60 noisysignal = 1'b0;
        wait_neg(8);
        check("short60_level", {31'd0, conditioned}, 32'd0);
        #10.5 noisysignal = 1'b1;
        #79 noisysignal = 1'b0;
        wait_neg(8);
        check("short79_level", {31'd0, conditioned}, 32'd0);

        // 4: minimum accepted pulse, four sampling edges
        wait_neg(1);
        noisysignal = 1'b1;
        push_event(cyc + 6, EV_RISE);
        #80 noisysignal = 1'b0;
        push_event(cyc + 6, EV_FALL);
        wait_neg(10);
        check("minpulse_level", {31'd0, conditioned}, 32'd0);

        // 5: glitch train while high, ending low
        noisysignal = 1'b1;
        push_event(cyc + 6, EV_RISE);
        wait_neg(8);
        #5;
        for (int i = 0; i < 16; i++) begin
            noisysignal = i[0] ^ i[1];
            #10;
        end
        check("train_hold", {31'd0, conditioned}, 32'd1);
        @(negedge clk);
        push_event(cyc + 5, EV_FALL);
        wait_neg(10);
        check("train_level", {31'd0, conditioned}, 32'd0);

        // 6: reset two cycles into qualifying a rise restarts the count
        noisysignal = 1'b1;
        wait_neg(4);
        #3 reset = 1'b1;
        #1 check("midcount_cond", {31'd0, conditioned}, 32'd0);
        wait_neg(2);
        reset = 1'b0;
        push_event(cyc + 6, EV_RISE);
        wait_neg(10);
        check("midcount_level", {31'd0, conditioned}, 32'd1);

        // Reset clears a high output without waiting for a clock edge
        #3 reset = 1'b1;
        #1 check("async_clear", {31'd0, conditioned}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        push_event(cyc + 6, EV_RISE);
        wait_neg(10);
        check("async_rerise", {31'd0, conditioned}, 32'd1);

        check("pending_events", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
